// File: rtl/axi_stream_extract_header.sv
// axi_stream_extract_header
// Strips a 1..DATA_BYTE_WD byte header from the front of each AXI Stream
// packet. The header appears right-justified on a side channel. The remaining
// payload is re-packed into full, MSB-first beats.
// Optional build macro: AXIS_EXTRACT_ERR_CHECK_EN adds the err_short output,
// which flags short first beats and malformed keep patterns.
module axi_stream_extract_header #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    output logic                    ready_in,
    output logic                    valid_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    input  logic                    ready_out,
    input  logic                    valid_cfg,
    input  logic [BYTE_CNT_WD-1:0]  strip_byte_cnt,
    output logic                    ready_cfg,
    output logic                    valid_hdr,
    output logic [DATA_WD-1:0]      data_hdr,
    output logic [DATA_BYTE_WD-1:0] keep_hdr,
    input  logic                    ready_hdr
`ifdef AXIS_EXTRACT_ERR_CHECK_EN
    ,
    output logic                    err_short
`endif
);

    // Wide enough to hold H = DATA_BYTE_WD itself.
    localparam int CNT_W = $clog2(DATA_BYTE_WD + 1);

    typedef enum logic [1:0] {IDLE, FIRST, BODY, FLUSH} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        h_q, h_d;
    logic [DATA_WD-1:0]      hold_q, hold_d;
    logic [DATA_WD-1:0]      flush_data_q, flush_data_d;
    logic [DATA_BYTE_WD-1:0] flush_keep_q, flush_keep_d;

    logic                    valid_out_d, last_out_d;
    logic [DATA_WD-1:0]      data_out_d;
    logic [DATA_BYTE_WD-1:0] keep_out_d;
    logic                    valid_hdr_d;
    logic [DATA_WD-1:0]      data_hdr_d;
    logic [DATA_BYTE_WD-1:0] keep_hdr_d;

    logic [DATA_BYTE_WD-1:0] keep_eff;
    logic [DATA_WD-1:0]      data_m;
    logic [DATA_WD-1:0]      merged;
    logic                    out_free, hdr_free, in_fire;
    int                      n_bytes, h_bytes, r_bytes, p_bytes;

    // Top p lanes set (the first p bytes of a beat).
    function automatic logic [DATA_BYTE_WD-1:0] keep_top(input int p);
        logic [DATA_BYTE_WD-1:0] k;
        k = '0;
        for (int i = 0; i < DATA_BYTE_WD; i++) k[DATA_BYTE_WD-1-i] = (i < p);
        return k;
    endfunction

    // Low n lanes set (right-justified header enables).
    function automatic logic [DATA_BYTE_WD-1:0] keep_low(input int n);
        logic [DATA_BYTE_WD-1:0] k;
        k = '0;
        for (int i = 0; i < DATA_BYTE_WD; i++) k[i] = (i < n);
        return k;
    endfunction

    function automatic int popcount(input logic [DATA_BYTE_WD-1:0] k);
        int c;
        c = 0;
        for (int i = 0; i < DATA_BYTE_WD; i++) if (k[i]) c++;
        return c;
    endfunction

    function automatic logic [DATA_WD-1:0] byte_mask(input logic [DATA_BYTE_WD-1:0] k);
        logic [DATA_WD-1:0] m;
        for (int i = 0; i < DATA_BYTE_WD; i++) m[8*i +: 8] = {8{k[i]}};
        return m;
    endfunction

`ifdef AXIS_EXTRACT_ERR_CHECK_EN
    logic keep_bad;
    logic short_first;

    // Flag malformed keep patterns and treat such beats as fully populated.
    always_comb begin
        keep_bad = last_in ? (keep_in != keep_top(popcount(keep_in))) : (keep_in != '1);
        keep_eff = keep_bad ? '1 : keep_in;
    end

    assign short_first = (state_q == FIRST) & in_fire & last_in & (n_bytes < h_bytes);

    // One-cycle error pulse, registered alongside the header valid.
    always_ff @(posedge clk) begin
        if (!rst_n) err_short <= 1'b0;
        else        err_short <= (in_fire & keep_bad) | short_first;
    end
`else
    assign keep_eff = keep_in;
`endif

    assign out_free = ~valid_out | ready_out;
    assign hdr_free = ~valid_hdr | ready_hdr;
    assign in_fire  = valid_in & ready_in;

    // Readiness depends only on state and on whether the output slots can take data.
    always_comb begin
        ready_cfg = 1'b0;
        ready_in  = 1'b0;
        unique case (state_q)
            IDLE:    ready_cfg = 1'b1;
            // A last first beat may carry payload, so the payload slot must be free too.
            FIRST:   ready_in  = hdr_free & out_free;
            BODY:    ready_in  = out_free;
            default: ;
        endcase
    end

    // Next-state and datapath: split each accepted beat into header, payload and hold.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned, which would infer a latch.
        state_d      = state_q;
        h_d          = h_q;
        hold_d       = hold_q;
        flush_data_d = flush_data_q;
        flush_keep_d = flush_keep_q;
        valid_out_d  = valid_out & ~ready_out;
        data_out_d   = data_out;
        keep_out_d   = keep_out;
        last_out_d   = last_out;
        valid_hdr_d  = valid_hdr & ~ready_hdr;
        data_hdr_d   = data_hdr;
        keep_hdr_d   = keep_hdr;
        n_bytes      = popcount(keep_eff);
        h_bytes      = int'(h_q);
        r_bytes      = DATA_BYTE_WD - h_bytes;
        p_bytes      = r_bytes + n_bytes;
        data_m       = data_in & byte_mask(keep_eff);
        merged       = hold_q | (data_m >> (8 * r_bytes));

        unique case (state_q)
            IDLE: begin
                if (valid_cfg) begin
                    h_d     = CNT_W'(int'(strip_byte_cnt) + 1);
                    hold_d  = '0;
                    state_d = FIRST;
                end
            end

            FIRST: begin
                if (in_fire) begin
                    valid_hdr_d = 1'b1;
                    if (last_in && (n_bytes < h_bytes)) begin
                        data_hdr_d = data_m >> (8 * (DATA_BYTE_WD - n_bytes));
                        keep_hdr_d = keep_low(n_bytes);
                    end else begin
                        data_hdr_d = data_m >> (8 * r_bytes);
                        keep_hdr_d = keep_low(h_bytes);
                    end
                    // Residual bytes stay left-justified; with R=0 the shift clears the hold.
                    hold_d = data_m << (8 * h_bytes);
                    if (!last_in) begin
                        state_d = BODY;
                    end else begin
                        state_d = IDLE;
                        if (n_bytes > h_bytes) begin
                            valid_out_d = 1'b1;
                            data_out_d  = data_m << (8 * h_bytes);
                            keep_out_d  = keep_top(n_bytes - h_bytes);
                            last_out_d  = 1'b1;
                        end
                    end
                end
            end

            BODY: begin
                if (in_fire) begin
                    if (!last_in) begin
                        valid_out_d = 1'b1;
                        data_out_d  = merged;
                        keep_out_d  = '1;
                        last_out_d  = 1'b0;
                        hold_d      = data_m << (8 * h_bytes);
                    end else begin
                        state_d = IDLE;
                        if (p_bytes == 0) begin
                            valid_out_d = valid_out & ~ready_out;
                        end else if (p_bytes <= DATA_BYTE_WD) begin
                            valid_out_d = 1'b1;
                            data_out_d  = merged;
                            keep_out_d  = keep_top(p_bytes);
                            last_out_d  = 1'b1;
                        end else begin
                            valid_out_d  = 1'b1;
                            data_out_d   = merged;
                            keep_out_d   = '1;
                            last_out_d   = 1'b0;
                            flush_data_d = data_m << (8 * h_bytes);
                            flush_keep_d = keep_top(n_bytes - h_bytes);
                            state_d      = FLUSH;
                        end
                    end
                end
            end

            FLUSH: begin
                if (out_free) begin
                    valid_out_d = 1'b1;
                    data_out_d  = flush_data_q;
                    keep_out_d  = flush_keep_q;
                    last_out_d  = 1'b1;
                    state_d     = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        // NOTE: the hold and flush registers are reset too, so an aborted packet leaves no stale bytes behind.
        if (!rst_n) begin
            h_q          <= '0;
            hold_q       <= '0;
            flush_data_q <= '0;
            flush_keep_q <= '0;
            valid_out    <= 1'b0;
            data_out     <= '0;
            keep_out     <= '0;
            last_out     <= 1'b0;
            valid_hdr    <= 1'b0;
            data_hdr     <= '0;
            keep_hdr     <= '0;
        end else begin
            h_q          <= h_d;
            hold_q       <= hold_d;
            flush_data_q <= flush_data_d;
            flush_keep_q <= flush_keep_d;
            valid_out    <= valid_out_d;
            data_out     <= data_out_d;
            keep_out     <= keep_out_d;
            last_out     <= last_out_d;
            valid_hdr    <= valid_hdr_d;
            data_hdr     <= data_hdr_d;
            keep_hdr     <= keep_hdr_d;
        end
    end

endmodule

// File: tb/tb_axi_stream_extract_header.sv
// Testbench for axi_stream_extract_header: directed packets with scoreboards
// for the header side channel and the payload stream.
`timescale 1ns/1ps
module tb_axi_stream_extract_header;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } beat_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
    } hdr_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_in = 1'b0;
    logic [31:0] data_in = '0;
    logic [3:0]  keep_in = '0;
    logic        last_in = 1'b0;
    logic        ready_in;
    logic        valid_out;
    logic [31:0] data_out;
    logic [3:0]  keep_out;
    logic        last_out;
    logic        ready_out = 1'b1;
    logic        valid_cfg = 1'b0;
    logic [1:0]  strip_byte_cnt = '0;
    logic        ready_cfg;
    logic        valid_hdr;
    logic [31:0] data_hdr;
    logic [3:0]  keep_hdr;
    logic        ready_hdr = 1'b1;
`ifdef AXIS_EXTRACT_ERR_CHECK_EN
    logic        err_short;
    int          err_pulses = 0;
`endif

    int    checks = 0;
    int    failures = 0;
    beat_t exp_out_q[$];
    hdr_t  exp_hdr_q[$];
    beat_t mon_exp, out_seen;
    hdr_t  mon_hexp, hdr_seen;
    logic  out_stall = 1'b0;
    logic  hdr_stall = 1'b0;

    axi_stream_extract_header #(.DATA_WD(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .valid_in       (valid_in),
        .data_in        (data_in),
        .keep_in        (keep_in),
        .last_in        (last_in),
        .ready_in       (ready_in),
        .valid_out      (valid_out),
        .data_out       (data_out),
        .keep_out       (keep_out),
        .last_out       (last_out),
        .ready_out      (ready_out),
        .valid_cfg      (valid_cfg),
        .strip_byte_cnt (strip_byte_cnt),
        .ready_cfg      (ready_cfg),
        .valid_hdr      (valid_hdr),
        .data_hdr       (data_hdr),
        .keep_hdr       (keep_hdr),
        .ready_hdr      (ready_hdr)
`ifdef AXIS_EXTRACT_ERR_CHECK_EN
        ,
        .err_short      (err_short)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic exp_out(input logic [31:0] d, input logic [3:0] k, input logic l);
        beat_t b;
        b.data = d;
        b.keep = k;
        b.last = l;
        exp_out_q.push_back(b);
    endtask

    task automatic exp_hdr(input logic [31:0] d, input logic [3:0] k);
        hdr_t h;
        h.data = d;
        h.keep = k;
        exp_hdr_q.push_back(h);
    endtask

    // Payload and header monitors: pop on handshake, check stability while stalled.
    always @(negedge clk) begin
        if (out_stall) begin
            check("out_stall_valid", 64'(valid_out), 64'd1);
            check("out_stall_beat", 64'({data_out, keep_out, last_out}), 64'(out_seen));
        end
        if (valid_out && ready_out) begin
            check("out_expected", 64'(exp_out_q.size() > 0), 64'd1);
            if (exp_out_q.size() > 0) begin
                mon_exp = exp_out_q.pop_front();
                check("out_data", 64'(data_out), 64'(mon_exp.data));
                check("out_keep", 64'(keep_out), 64'(mon_exp.keep));
                check("out_last", 64'(last_out), 64'(mon_exp.last));
            end
        end
        if (hdr_stall) begin
            check("hdr_stall_valid", 64'(valid_hdr), 64'd1);
            check("hdr_stall_data", 64'({data_hdr, keep_hdr}), 64'(hdr_seen));
        end
        if (valid_hdr && ready_hdr) begin
            check("hdr_expected", 64'(exp_hdr_q.size() > 0), 64'd1);
            if (exp_hdr_q.size() > 0) begin
                mon_hexp = exp_hdr_q.pop_front();
                check("hdr_data", 64'(data_hdr), 64'(mon_hexp.data));
                check("hdr_keep", 64'(keep_hdr), 64'(mon_hexp.keep));
            end
        end
        out_stall <= rst_n & valid_out & ~ready_out;
        out_seen  <= {data_out, keep_out, last_out};
        hdr_stall <= rst_n & valid_hdr & ~ready_hdr;
        hdr_seen  <= {data_hdr, keep_hdr};
    end

`ifdef AXIS_EXTRACT_ERR_CHECK_EN
    // Count error pulses.
    always @(negedge clk) begin
        if (err_short) err_pulses <= err_pulses + 1;
    end
`endif

    task automatic send_cfg(input logic [1:0] cnt);
        int  budget;
        bit  done;
        budget = 0;
        done = 1'b0;
        valid_cfg = 1'b1;
        strip_byte_cnt = cnt;
        while (!done && budget < 100) begin
            @(negedge clk);
            done = ready_cfg;
            @(posedge clk);
            budget++;
        end
        #1 valid_cfg = 1'b0;
        check("cfg_accepted", 64'(done), 64'd1);
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        int  budget;
        bit  done;
        budget = 0;
        done = 1'b0;
        valid_in = 1'b1;
        data_in = d;
        keep_in = k;
        last_in = l;
        while (!done && budget < 100) begin
            @(negedge clk);
            done = ready_in;
            @(posedge clk);
            budget++;
        end
        #1 valid_in = 1'b0;
        check("beat_accepted", 64'(done), 64'd1);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_out_q.size() != 0 || exp_hdr_q.size() != 0) && n < 200) begin
            @(posedge clk);
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        check("drain_out", 64'(exp_out_q.size()), 64'd0);
        check("drain_hdr", 64'(exp_hdr_q.size()), 64'd0);
    endtask

    initial begin
        // Reset values.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid_out", 64'(valid_out), 64'd0);
        check("rst_valid_hdr", 64'(valid_hdr), 64'd0);
        check("rst_data_out", 64'({data_out, keep_out, last_out}), 64'd0);
        check("rst_data_hdr", 64'({data_hdr, keep_hdr}), 64'd0);
        check("rst_ready_cfg", 64'(ready_cfg), 64'd1);
        check("rst_ready_in", 64'(ready_in), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // H=2 across three beats.
        exp_hdr(32'h0000AABB, 4'b0011);
        exp_out(32'hCCDD1122, 4'b1111, 1'b0);
        exp_out(32'h33445566, 4'b1111, 1'b1);
        send_cfg(2'd1);
        send_beat(32'hAABBCCDD, 4'b1111, 1'b0);
        send_beat(32'h11223344, 4'b1111, 1'b0);
        send_beat(32'h55667788, 4'b1100, 1'b1);
        wait_drain();

        // H=1, last beat spills into a flush beat.
        exp_hdr(32'h000000AA, 4'b0001);
        exp_out(32'hBBCCDD11, 4'b1111, 1'b0);
        exp_out(32'h22330000, 4'b1100, 1'b1);
        send_cfg(2'd0);
        send_beat(32'hAABBCCDD, 4'b1111, 1'b0);
        send_beat(32'h11223344, 4'b1110, 1'b1);
        wait_drain();

        // H=4 single beat: header only, config ready right away.
        exp_hdr(32'hDEADBEEF, 4'b1111);
        send_cfg(2'd3);
        send_beat(32'hDEADBEEF, 4'b1111, 1'b1);
        check("h4_ready_cfg", 64'(ready_cfg), 64'd1);
        wait_drain();

        // H=4 (R=0) two beats: payload is the second beat unchanged.
        exp_hdr(32'h01020304, 4'b1111);
        exp_out(32'h05060708, 4'b1111, 1'b1);
        send_cfg(2'd3);
        send_beat(32'h01020304, 4'b1111, 1'b0);
        send_beat(32'h05060708, 4'b1111, 1'b1);
        wait_drain();

        // H=1 single full beat: payload from the first beat itself.
        exp_hdr(32'h00000011, 4'b0001);
        exp_out(32'h22334400, 4'b1110, 1'b1);
        send_cfg(2'd0);
        send_beat(32'h11223344, 4'b1111, 1'b1);
        wait_drain();

`ifdef AXIS_EXTRACT_ERR_CHECK_EN
        check("err_none_yet", 64'(err_pulses), 64'd0);
`endif
        // Short first beat: H=3 but only two bytes arrive.
        exp_hdr(32'h0000AABB, 4'b0011);
        send_cfg(2'd2);
        send_beat(32'hAABB0000, 4'b1100, 1'b1);
`ifdef AXIS_EXTRACT_ERR_CHECK_EN
        check("short_err_pulse", 64'(err_short), 64'd1);
        check("short_err_with_hdr", 64'(valid_hdr), 64'd1);
`endif
        wait_drain();
`ifdef AXIS_EXTRACT_ERR_CHECK_EN
        check("err_after_short", 64'(err_pulses), 64'd1);
`endif

        // Backpressure on both output channels during the H=2 packet.
        exp_hdr(32'h0000AABB, 4'b0011);
        exp_out(32'hCCDD1122, 4'b1111, 1'b0);
        exp_out(32'h33445566, 4'b1111, 1'b1);
        send_cfg(2'd1);
        ready_hdr = 1'b0;
        fork
            begin
                send_beat(32'hAABBCCDD, 4'b1111, 1'b0);
                send_beat(32'h11223344, 4'b1111, 1'b0);
                send_beat(32'h55667788, 4'b1100, 1'b1);
            end
            begin
                repeat (2) @(posedge clk);
                #1 ready_out = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check("stall_ready_in", 64'(ready_in), 64'd0);
                    @(posedge clk);
                end
                #1 ready_out = 1'b1;
            end
            begin
                repeat (5) @(posedge clk);
                #1 ready_hdr = 1'b1;
            end
        join
        wait_drain();

        // Reset in BODY discards the held bytes; next packet must be exact.
        exp_hdr(32'h0000AABB, 4'b0011);
        exp_out(32'hCCDD1122, 4'b1111, 1'b0);
        send_cfg(2'd1);
        send_beat(32'hAABBCCDD, 4'b1111, 1'b0);
        send_beat(32'h11223344, 4'b1111, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("midrst_valid_out", 64'(valid_out), 64'd0);
        check("midrst_valid_hdr", 64'(valid_hdr), 64'd0);
        check("midrst_ready_cfg", 64'(ready_cfg), 64'd1);
        check("midrst_ready_in", 64'(ready_in), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        exp_hdr(32'h000000AA, 4'b0001);
        exp_out(32'hBBCCDD11, 4'b1111, 1'b0);
        exp_out(32'h22330000, 4'b1100, 1'b1);
        send_cfg(2'd0);
        send_beat(32'hAABBCCDD, 4'b1111, 1'b0);
        send_beat(32'h11223344, 4'b1110, 1'b1);
        wait_drain();

`ifdef AXIS_EXTRACT_ERR_CHECK_EN
        // Single-byte short beat with H=2.
        exp_hdr(32'h000000AA, 4'b0001);
        send_cfg(2'd1);
        send_beat(32'hAA000000, 4'b1000, 1'b1);
        check("err_pulse_short1", 64'(err_short), 64'd1);
        wait_drain();
        check("err_after_short1", 64'(err_pulses), 64'd2);

        // Keep hole on a non-last beat: data passes as if keep were all-ones.
        exp_hdr(32'h00000102, 4'b0011);
        exp_out(32'h03040506, 4'b1111, 1'b0);
        exp_out(32'h07080000, 4'b1100, 1'b1);
        send_cfg(2'd1);
        send_beat(32'h01020304, 4'b1110, 1'b0);
        send_beat(32'h05060708, 4'b1111, 1'b1);
        wait_drain();
        check("err_after_keep", 64'(err_pulses), 64'd3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
